// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, with sign fix-up and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; special divide cases resolve here straight to DONE
// CALC  | one shift-add / shift-subtract iteration per cycle, WIDTH iterations
// FIX   | sign correction and result selection, result register written
// DONE  | done pulse for one cycle, then back to IDLE
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op;
  logic             neg;
  logic [WIDTH-1:0] opnd;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;

  // operand decode at accept time
  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special, neg_in;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_sgn & a[WIDTH-1];
    b_neg    = b_sgn & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !funct3[0] && (a == SMIN) && (b == '1);
    special  = div_zero | div_ovf;
    // remainder takes the dividend's sign, everything else the product of signs
    neg_in   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero)
      special_res = funct3[1] ? a : '1;
    else
      special_res = funct3[1] ? '0 : a;
  end

  // one iteration of each loop
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [AW-1:0]    mul_add, acc_mul, div_sh, acc_div;
  logic             div_borrow;

  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_add    = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : acc;
    acc_mul    = mul_add >> 1;
    div_sh     = {acc[AW-2:0], 1'b0};
    div_diff   = div_sh[AW-1:WIDTH] - {1'b0, opnd};
    div_borrow = div_sh[AW-1:WIDTH] < {1'b0, opnd};
    acc_div    = div_borrow ? div_sh : {div_diff, div_sh[WIDTH-1:1], 1'b1};
  end

  // sign fix-up and output selection
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op[2])
      fix_res = op[1] ? rem_fix : quo_fix;
    else if (op[1:0] == 2'b00)
      fix_res = prod_fix[WIDTH-1:0];
    else
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST)
          state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= '0;
      neg    <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op   <= funct3;
            neg  <= neg_in;
            cnt  <= '0;
            opnd <= is_div ? b_mag : a_mag;
            acc  <= {{(WIDTH + 1){1'b0}}, (is_div ? a_mag : b_mag)};
            if (special)
              result <= special_res;
          end
        end
        CALC: begin
          acc <= op[2] ? acc_div : acc_mul;
          cnt <= cnt + 1'b1;
        end
        FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: a 32-bit and an 8-bit instance
// exercised with hand-computed vectors, latency and protocol checks.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  f3_32, f3_8;
  logic [31:0] a32, b32, res32;
  logic [7:0]  a8, b8, res8;
  logic        busy32, done32, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .funct3(f3_32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .funct3(f3_8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit w8, input logic s, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y);
    if (w8) begin
      start8 = s; f3_8 = f; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = s; f3_32 = f; a32 = x; b32 = y;
    end
  endtask

  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic [31:0] get_res(input bit w8);
    return w8 ? {24'h0, res8} : res32;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that
  // takes the DUT from DONE back to IDLE.
  task automatic run_op(input bit w8, input string tag, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int pulse_at, input logic [31:0] hold_exp);
    int lat;
    int nbusy;
    set_in(w8, 1'b1, f, x, y);
    @(posedge clk); #1;
    set_in(w8, 1'b0, ~f, ~x, y ^ 32'h5a5a_5a5a);
    lat   = 1;
    nbusy = 0;
    while (!get_done(w8) && lat < 200) begin
      if (get_busy(w8)) nbusy++;
      if (lat == pulse_at) begin
        chk({tag, ".hold"}, get_res(w8), hold_exp);
        set_in(w8, 1'b1, 3'b101, 32'd99, 32'd0);
      end else if (lat == pulse_at + 1) begin
        set_in(w8, 1'b0, 3'b000, 32'd0, 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".done"}, {31'd0, get_done(w8)}, 32'd1);
    chk({tag, ".busy_at_done"}, {31'd0, get_busy(w8)}, 32'd0);
    chk({tag, ".res"}, get_res(w8), exp_res);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    @(posedge clk); #1;
    chk({tag, ".one_pulse"}, {31'd0, get_done(w8)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, lat, ndone;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst.busy32", {31'd0, busy32}, 32'd0);
    chk("rst.done32", {31'd0, done32}, 32'd0);
    chk("rst.res32", res32, 32'd0);
    chk("rst.busy8", {31'd0, busy8}, 32'd0);
    chk("rst.res8", {24'd0, res8}, 32'd0);

    // multiply, WIDTH=32
    run_op(0, "mul_7x6",    3'b000, 32'd7,          32'd6,          32'd42,         34, 0, 0);
    run_op(0, "mulh_m1",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  34, 0, 0);
    run_op(0, "mulhsu_m1",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, 0, 0);
    run_op(0, "mulhu_m1",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34, 0, 0);
    run_op(0, "mul_neg",    3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  34, 0, 0);
    run_op(0, "mulh_min",   3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34, 0, 0);

    // divide, WIDTH=32
    run_op(0, "div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0, 0);
    run_op(0, "rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0, 0);
    run_op(0, "div_7_m2",   3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 0, 0);
    run_op(0, "rem_7_m2",   3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, 0, 0);
    run_op(0, "divu_3_10",  3'b101, 32'd3,          32'd10,         32'd0,          34, 0, 0);
    run_op(0, "div_min_1",  3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000,  34, 0, 0);
    run_op(0, "divu_100_7", 3'b101, 32'd100,        32'd7,          32'd14,         34, 0, 0);
    run_op(0, "remu_100_7", 3'b111, 32'd100,        32'd7,          32'd2,          34, 0, 0);

    // special cases resolve in one cycle
    run_op(0, "div_by0",    3'b100, 32'd55,         32'd0,          32'hFFFF_FFFF,  1, 0, 0);
    run_op(0, "remu_by0",   3'b111, 32'h1234,       32'd0,          32'h1234,       1, 0, 0);
    run_op(0, "div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 0);
    run_op(0, "rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, 0, 0);
    run_op(0, "divu_by0",   3'b101, 32'd9,          32'd0,          32'hFFFF_FFFF,  1, 0, 0);

    // start pulsed mid-CALC is ignored; previous result (0xFFFFFFFF) held meanwhile
    run_op(0, "mul_ignore", 3'b000, 32'd3,          32'd5,          32'd15,         34, 10, 32'hFFFF_FFFF);

    // reset in the middle of a DIV
    set_in(0, 1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk); #1;
    set_in(0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid.busy", {31'd0, busy32}, 32'd0);
    chk("rstmid.done", {31'd0, done32}, 32'd0);
    chk("rstmid.res", res32, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("rstmid.no_done", 32'(ndone), 32'd0);
    run_op(0, "after_rst",  3'b101, 32'd100,        32'd7,          32'd14,         34, 0, 0);

    // WIDTH=8 instance
    run_op(1, "w8_mulhu",   3'b011, 32'hFF,         32'hFF,         32'hFE,         10, 0, 0);
    run_op(1, "w8_div_ovf", 3'b100, 32'h80,         32'hFF,         32'h80,         1,  0, 0);
    run_op(1, "w8_mul",     3'b000, 32'h0F,         32'h11,         32'hFF,         10, 0, 0);
    run_op(1, "w8_div",     3'b100, 32'hF9,         32'h02,         32'hFD,         10, 0, 0);
    run_op(1, "w8_rem",     3'b110, 32'hF9,         32'h02,         32'hFF,         10, 0, 0);

    // start held high: accepted once every WIDTH+3 cycles
    t1 = -1;
    t2 = -1;
    set_in(1, 1'b1, 3'b011, 32'hFF, 32'hFF);
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (t1 < 0) t1 = i;
        else        t2 = i;
      end
    end
    set_in(1, 1'b0, 3'b000, 32'd0, 32'd0);
    chk("b2b.gap", 32'(t2 - t1), 32'd11);
    chk("b2b.res", {24'd0, res8}, 32'hFE);
    @(posedge clk); #1;

    // 32-bit back-to-back after 8-bit activity, plus latency re-check
    lat = 0;
    set_in(0, 1'b1, 3'b011, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk); #1;
    set_in(0, 1'b0, 3'b000, 32'd0, 32'd0);
    lat = 1;
    while (!done32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mulhu_2p16.res", res32, 32'd1);
    chk("mulhu_2p16.lat", 32'(lat), 32'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
